// File: rtl/vec_mem_sequencer.sv
// Address sequencer for vector load/store: one memory request per element, address stepped by stride.
// Optional abort input enabled by defining VSEQ_ABORT_EN.
module vec_mem_sequencer #(
    parameter int unsigned VLEN_MAX = 16,
    parameter int unsigned ADDR_W   = 32
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            Start_IN,
    input  logic                            IsStore_IN,
    input  logic [ADDR_W-1:0]               Base_IN,
    input  logic [ADDR_W-1:0]               ExtImm_IN,
    input  logic [$clog2(VLEN_MAX+1)-1:0]   VLen_IN,
    input  logic                            MemReady_IN,
`ifdef VSEQ_ABORT_EN
    input  logic                            Abort_IN,
`endif
    output logic                            MemValid_OUT,
    output logic                            MemWrite_OUT,
    output logic [ADDR_W-1:0]               MemAddr_OUT,
    output logic [$clog2(VLEN_MAX)-1:0]     ElemIdx_OUT,
    output logic                            Busy_OUT,
    output logic                            Done_OUT
);

    localparam int unsigned LEN_W = $clog2(VLEN_MAX + 1);
    localparam int unsigned IDX_W = $clog2(VLEN_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   stride_q, stride_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic                store_q, store_d;
    logic                valid_q, busy_q, done_q;

    // State and operand registers; status flags are registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            stride_q <= '0;
            idx_q    <= '0;
            len_q    <= '0;
            store_q  <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            stride_q <= stride_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            store_q  <= store_d;
            valid_q  <= (state_d == ISSUE);
            busy_q   <= (state_d != IDLE);
            done_q   <= (state_d == DONE);
        end
    end

    // Next-state and operand update logic.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        stride_d = stride_q;
        idx_d    = idx_q;
        len_d    = len_q;
        store_d  = store_q;
        case (state_q)
            IDLE: begin
                if (Start_IN) begin
                    store_d  = IsStore_IN;
                    stride_d = ExtImm_IN;
                    addr_d   = Base_IN;
                    idx_d    = '0;
                    len_d    = (VLen_IN > LEN_W'(VLEN_MAX)) ? LEN_W'(VLEN_MAX) : VLen_IN;
                    state_d  = (len_d == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                // Request is always valid here, so ready alone marks a handshake.
                if (MemReady_IN) begin
                    if (LEN_W'(idx_q) == len_q - LEN_W'(1)) begin
                        state_d = DONE;
                    end else begin
                        addr_d = addr_q + stride_q;
                        idx_d  = idx_q + IDX_W'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
`ifdef VSEQ_ABORT_EN
        if (Abort_IN && (state_q != IDLE)) begin
            state_d = IDLE;
        end
`endif
    end

    assign MemValid_OUT = valid_q;
    assign MemWrite_OUT = store_q;
    assign MemAddr_OUT  = addr_q;
    assign ElemIdx_OUT  = idx_q;
    assign Busy_OUT     = busy_q;
    assign Done_OUT     = done_q;

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Self-checking bench for vec_mem_sequencer: directed and random ops against an element-list model.
module tb_vec_mem_sequencer;

    localparam int unsigned VLEN_MAX = 16;
    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned LEN_W    = $clog2(VLEN_MAX + 1);
    localparam int unsigned IDX_W    = $clog2(VLEN_MAX);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              Start_IN = 1'b0;
    logic              IsStore_IN = 1'b0;
    logic [ADDR_W-1:0] Base_IN = '0;
    logic [ADDR_W-1:0] ExtImm_IN = '0;
    logic [LEN_W-1:0]  VLen_IN = '0;
    logic              MemReady_IN = 1'b0;
`ifdef VSEQ_ABORT_EN
    logic              Abort_IN = 1'b0;
`endif
    logic              MemValid_OUT;
    logic              MemWrite_OUT;
    logic [ADDR_W-1:0] MemAddr_OUT;
    logic [IDX_W-1:0]  ElemIdx_OUT;
    logic              Busy_OUT;
    logic              Done_OUT;

    int unsigned total = 0;
    int unsigned bad   = 0;

    vec_mem_sequencer #(.VLEN_MAX(VLEN_MAX), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .Start_IN     (Start_IN),
        .IsStore_IN   (IsStore_IN),
        .Base_IN      (Base_IN),
        .ExtImm_IN    (ExtImm_IN),
        .VLen_IN      (VLen_IN),
        .MemReady_IN  (MemReady_IN),
`ifdef VSEQ_ABORT_EN
        .Abort_IN     (Abort_IN),
`endif
        .MemValid_OUT (MemValid_OUT),
        .MemWrite_OUT (MemWrite_OUT),
        .MemAddr_OUT  (MemAddr_OUT),
        .ElemIdx_OUT  (ElemIdx_OUT),
        .Busy_OUT     (Busy_OUT),
        .Done_OUT     (Done_OUT)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, 32'(MemValid_OUT), 32'd0);
        check({tag, "_busy"},  32'(Busy_OUT),     32'd0);
        check({tag, "_done"},  32'(Done_OUT),     32'd0);
    endtask

    // Runs one op from a negedge in IDLE; the model is the list of element addresses base + k*stride.
    task automatic run_op(input logic [31:0] base, input logic [31:0] stride, input int unsigned vlen,
                          input bit store, input int unsigned hold0, input bit rnd, input bit disturb);
        int unsigned n;
        int unsigned k;
        int unsigned cyc;
        bit          rdy;
        bit          finished;
        n        = (vlen > VLEN_MAX) ? VLEN_MAX : vlen;
        k        = 0;
        cyc      = 0;
        finished = 1'b0;
        Start_IN    = 1'b1;
        Base_IN     = base;
        ExtImm_IN   = stride;
        VLen_IN     = LEN_W'(vlen);
        IsStore_IN  = store;
        MemReady_IN = 1'($urandom);
        @(posedge clk);
        @(negedge clk);
        Start_IN = 1'b0;
        while (cyc < 200) begin
            cyc++;
            if (disturb) begin
                Base_IN    = $urandom;
                ExtImm_IN  = $urandom;
                VLen_IN    = LEN_W'($urandom);
                IsStore_IN = 1'($urandom);
                Start_IN   = 1'($urandom);
            end
            check("busy", 32'(Busy_OUT), 32'd1);
            if (k < n) begin
                check("valid", 32'(MemValid_OUT), 32'd1);
                check("done_early", 32'(Done_OUT), 32'd0);
                check("addr", MemAddr_OUT, base + 32'(k) * stride);
                check("idx", 32'(ElemIdx_OUT), k);
                check("write", 32'(MemWrite_OUT), 32'(store));
                if (cyc <= hold0) rdy = 1'b0;
                else if (rnd)     rdy = 1'($urandom_range(0, 1));
                else              rdy = 1'b1;
            end else begin
                check("valid_in_done", 32'(MemValid_OUT), 32'd0);
                check("done", 32'(Done_OUT), 32'd1);
                rdy = 1'($urandom);
            end
            MemReady_IN = rdy;
            @(posedge clk);
            @(negedge clk);
            if (k == n) begin
                finished = 1'b1;
                break;
            end
            if (rdy) k++;
        end
        Start_IN = 1'b0;
        check("op_finished", 32'(finished), 32'd1);
        if (!rnd && hold0 == 0) check("busy_cycles", cyc, n + 1);
        check_idle_outputs("after_op");
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(MemValid_OUT), 32'd0);
        check("rst_write", 32'(MemWrite_OUT), 32'd0);
        check("rst_addr",  MemAddr_OUT,       32'd0);
        check("rst_idx",   32'(ElemIdx_OUT),  32'd0);
        check("rst_busy",  32'(Busy_OUT),     32'd0);
        check("rst_done",  32'(Done_OUT),     32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(32'h0000_1000, 32'd4, 4, 1'b0, 0, 1'b0, 1'b0);
        run_op(32'h0000_0020, 32'd8, 2, 1'b1, 3, 1'b0, 1'b0);
        run_op(32'h0000_0004, 32'hFFFF_FFFC, 3, 1'b0, 0, 1'b0, 1'b0);
        run_op(32'h0000_0300, 32'd4, 0, 1'b1, 0, 1'b0, 1'b0);
        run_op(32'h0000_4000, 32'd2, 20, 1'b0, 0, 1'b0, 1'b0);
        run_op(32'h0000_8000, 32'h40, 5, 1'b1, 1, 1'b1, 1'b1);

        for (int i = 0; i < 24; i++) begin
            run_op($urandom, $urandom, $urandom_range(0, 20), 1'($urandom),
                   $urandom_range(0, 2), 1'b1, 1'b1);
        end

        // Asynchronous reset during element 2 of 4.
        Start_IN = 1'b1; Base_IN = 32'h100; ExtImm_IN = 32'h10; VLen_IN = LEN_W'(4); IsStore_IN = 1'b1;
        MemReady_IN = 1'b1;
        @(posedge clk); @(negedge clk);
        Start_IN = 1'b0;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        check("pre_rst_idx", 32'(ElemIdx_OUT), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(MemValid_OUT), 32'd0);
        check("arst_write", 32'(MemWrite_OUT), 32'd0);
        check("arst_addr",  MemAddr_OUT,       32'd0);
        check("arst_idx",   32'(ElemIdx_OUT),  32'd0);
        check("arst_busy",  32'(Busy_OUT),     32'd0);
        check("arst_done",  32'(Done_OUT),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("post_rst");

`ifdef VSEQ_ABORT_EN
        // Abort during element 1 of 4 returns to IDLE without a completion pulse.
        Start_IN = 1'b1; Base_IN = 32'h40; ExtImm_IN = 32'd4; VLen_IN = LEN_W'(4); IsStore_IN = 1'b0;
        MemReady_IN = 1'b1;
        @(posedge clk); @(negedge clk);
        Start_IN = 1'b0;
        @(posedge clk); @(negedge clk);
        check("pre_abort_idx", 32'(ElemIdx_OUT), 32'd1);
        Abort_IN = 1'b1;
        @(posedge clk); @(negedge clk);
        Abort_IN = 1'b0;
        check_idle_outputs("abort");
        @(negedge clk);
        check_idle_outputs("post_abort");
`endif

        run_op(32'h0000_0010, 32'd1, 2, 1'b0, 0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
